// File: rtl/score_bcd_converter.sv
// score_bcd_converter
// Converts the binary game score to packed BCD for the seven-segment drivers.
// An iterative double-dabble (shift-add-3) engine runs only when the score
// changes or a re-conversion is forced. bcd_out is written once per finished
// conversion and stays stable while the next result is being built.
// The re-conversion request is named force_req because "force" is a reserved
// word in SystemVerilog.
module score_bcd_converter #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  Clk,
    input  logic                  reset_rtl_0,
    input  logic [WIDTH-1:0]      bin_in,
    input  logic                  force_req,
    output logic [DIGITS*4-1:0]   bcd_out,
    output logic                  valid,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int BCD_W = DIGITS * 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_last_bin;
    logic               r_pending;
    logic [WIDTH-1:0]   r_shreg;
    logic [BCD_W-1:0]   r_scratch;
    logic [CNT_W-1:0]   r_count;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_valid;
    logic               r_done;
    logic [BCD_W-1:0]   w_corr;
    logic               w_trigger;

    // Double-dabble digit correction: a digit of 5 or more gets +3 before the shift.
    function automatic logic [3:0] add3(input logic [3:0] d);
        logic [3:0] r;
        if (d >= 4'd5) begin
            r = d + 4'd3;
        end else begin
            r = d;
        end
        return r;
    endfunction

    // Correct every scratch digit in parallel from its pre-shift value.
    always_comb begin
        w_corr = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_corr[4*i +: 4] = add3(r_scratch[4*i +: 4]);
        end
    end

    // A new conversion is wanted on a pending/forced request or a changed score.
    always_comb begin
        w_trigger = r_pending | force_req | (bin_in != r_last_bin);
    end

    // State register.
    always_ff @(posedge Clk or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: capture in IDLE, WIDTH shifts, one FINISH cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_trigger) begin
                    w_state_next = ST_SHIFT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (r_count == CNT_W'(1)) begin
                    w_state_next = ST_FINISH;
                end else begin
                    w_state_next = ST_SHIFT;
                end
            end
            ST_FINISH: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Conversion datapath and registered outputs; bcd_out only changes in FINISH.
    always_ff @(posedge Clk or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            r_last_bin <= '0;
            r_pending  <= 1'b1;
            r_shreg    <= '0;
            r_scratch  <= '0;
            r_count    <= '0;
            r_bcd      <= '0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= (r_state == ST_FINISH);
            case (r_state)
                ST_IDLE: begin
                    if (w_trigger) begin
                        r_shreg    <= bin_in;
                        r_last_bin <= bin_in;
                        r_scratch  <= '0;
                        r_count    <= CNT_W'(WIDTH);
                        r_pending  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    {r_scratch, r_shreg} <= {w_corr, r_shreg} << 1;
                    r_count <= r_count - CNT_W'(1);
                    if (force_req) begin
                        r_pending <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    r_bcd   <= r_scratch;
                    r_valid <= 1'b1;
                    if (force_req) begin
                        r_pending <= 1'b1;
                    end
                end
                default: begin
                    r_pending <= 1'b1;
                end
            endcase
        end
    end

    assign bcd_out = r_bcd;
    assign valid   = r_valid;
    assign done    = r_done;
    assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_score_bcd_converter.sv
// Self-checking bench for score_bcd_converter: expected BCD words are queued
// when a score is driven and compared whenever the DUT pulses done.
module tb_score_bcd_converter;

    logic        Clk = 1'b0;
    logic        reset_rtl_0 = 1'b0;
    logic [15:0] bin_in = 16'd0;
    logic        force_req = 1'b0;
    logic [19:0] bcd_out;
    logic        valid;
    logic        busy;
    logic        done;

    int          checks = 0;
    int          failures = 0;
    int          done_cnt = 0;
    logic [19:0] exp_q[$];
    logic [19:0] prev_bcd = 20'd0;

    score_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
        .Clk         (Clk),
        .reset_rtl_0 (reset_rtl_0),
        .bin_in      (bin_in),
        .force_req   (force_req),
        .bcd_out     (bcd_out),
        .valid       (valid),
        .busy        (busy),
        .done        (done)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int x;
        r = 20'd0;
        x = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Scoreboard consumer and tear check, sampled on the falling edge.
    always @(negedge Clk) begin
        if (reset_rtl_0) begin
            if (bcd_out != prev_bcd) chk("no_tear", 32'(done), 32'd1);
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_done", 32'd0, 32'd1);
                end else begin
                    chk("bcd", 32'(bcd_out), 32'(exp_q.pop_front()));
                    chk("valid_on_done", 32'(valid), 32'd1);
                end
            end
        end
        prev_bcd = bcd_out;
    end

    task automatic drive(input int v);
        bin_in = 16'(v);
        exp_q.push_back(to_bcd(v));
    endtask

    task automatic wait_done(input string tag, input int max);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(posedge Clk);
            #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Called just before the capture edge; checks the exact busy/done timing.
    task automatic check_latency(input string tag);
        @(posedge Clk); #1;
        chk({tag, "_busy_after_capture"}, 32'(busy), 32'd1);
        chk({tag, "_done_low_early"}, 32'(done), 32'd0);
        repeat (16) @(posedge Clk);
        #1;
        chk({tag, "_done_low_c16"}, 32'(done), 32'd0);
        chk({tag, "_busy_c16"}, 32'(busy), 32'd1);
        @(posedge Clk); #1;
        chk({tag, "_done_c17"}, 32'(done), 32'd1);
        chk({tag, "_valid_c17"}, 32'(valid), 32'd1);
        chk({tag, "_busy_low_c17"}, 32'(busy), 32'd0);
        @(posedge Clk); #1;
        chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        int n0;

        // Reset state.
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_bcd", 32'(bcd_out), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        // Release: pending forces a conversion of 0 at the first edge.
        drive(0);
        @(negedge Clk); #1 reset_rtl_0 = 1'b1;
        check_latency("init");

        // 12345, then a long quiet hold.
        drive(12345);
        wait_done("c12345", 40);
        n0 = done_cnt;
        repeat (200) @(posedge Clk);
        #1;
        chk("hold_no_done", 32'(done_cnt), 32'(n0 + 1));
        chk("hold_busy", 32'(busy), 32'd0);
        chk("hold_bcd", 32'(bcd_out), 32'h12345);

        // Boundary values.
        drive(65535); wait_done("c65535", 40);
        drive(0);     wait_done("c0", 40);
        drive(9);     wait_done("c9", 40);

        // Score changes mid-conversion: old value finishes, new one follows.
        drive(100);
        repeat (4) @(posedge Clk);
        #1 drive(27000);
        wait_done("c100", 40);
        wait_done("c27000", 40);

        // Force during SHIFT with a constant score: exactly two conversions.
        @(posedge Clk); #1;
        n0 = done_cnt;
        drive(999);
        repeat (4) @(posedge Clk);
        #1 force_req = 1'b1;
        exp_q.push_back(to_bcd(999));
        @(posedge Clk); #1 force_req = 1'b0;
        wait_done("force1", 40);
        wait_done("force2", 40);
        repeat (40) @(posedge Clk);
        #1;
        chk("force_two_dones", 32'(done_cnt - n0), 32'd2);

        // Reset in the middle of converting 4242.
        drive(4242);
        @(posedge Clk);            // capture
        repeat (8) @(posedge Clk); // shift 8
        #2 reset_rtl_0 = 1'b0;
        #1;
        chk("midrst_bcd", 32'(bcd_out), 32'd0);
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        repeat (2) @(posedge Clk);
        @(negedge Clk); #1 reset_rtl_0 = 1'b1;
        check_latency("rerun4242");
        chk("final_bcd", 32'(bcd_out), 32'h04242);

        repeat (5) @(posedge Clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/score_bcd_converter.md
# score_bcd_converter

Sequential binary-to-BCD converter between the game score counter and the two seven-segment HexDriver instances. Replaces per-digit divide/subtract arithmetic with an iterative double-dabble (shift-add-3) engine. Watches the binary score, re-converts only when it changes, and holds a stable, glitch-free BCD word for the display drivers.

## Interface
- WIDTH, 16, binary input width
- DIGITS, 5, BCD output digits; DIGITS*4 bits must represent 2^WIDTH-1 (16 bits -> 5 digits)
- Clk  input  1  system clock, 100 MHz domain; all state on rising edge
- reset_rtl_0  input  1  asynchronous, active-low reset (asserts immediately, released synchronously by the integrator)
- bin_in  input  WIDTH  binary score, unsigned; sampled only at capture
- force  input  1  single-cycle request to re-convert even if bin_in is unchanged
- bcd_out  output  DIGITS*4  packed BCD, digit 0 (ones) in [3:0], digit 4 in [19:16]
- valid  output  1  bcd_out holds a completed conversion
- busy  output  1  conversion in progress
- done  output  1  one-cycle pulse when bcd_out updates

## Operation
- Registers: last_bin (WIDTH), pending (1), shreg (WIDTH), scratch (DIGITS*4), count (ceil(log2(WIDTH+1))), state.
- States: IDLE, SHIFT, FINISH.
- IDLE: trigger = pending | force | (bin_in != last_bin). On trigger at edge C:
  - shreg <= bin_in, last_bin <= bin_in, scratch <= 0, count <= WIDTH, pending <= 0, state <= SHIFT.
- SHIFT, each edge:
  - every 4-bit digit of scratch >= 5 gets +3 (all digits corrected in parallel, from pre-shift values).
  - {scratch, shreg} <= ({corrected scratch, shreg}) << 1.
  - count <= count - 1; when count == 1 on this edge, state <= FINISH.
- FINISH, one edge: bcd_out <= scratch, valid <= 1, done <= 1, state <= IDLE.
- done is cleared on every edge where state is not FINISH.
- busy = (state != IDLE), registered-equivalent (decoded from the state register, no combinational path from inputs).
- bin_in changes during SHIFT/FINISH are not sampled. Detection happens in IDLE by comparing against last_bin, so the newest value is converted afterwards. Intermediate values may be skipped.
- force during SHIFT/FINISH sets pending <= 1. It is never lost.
- Simultaneous force and bin_in change in IDLE: a single conversion of the current bin_in.
- bcd_out is never written except in FINISH. It holds the previous result throughout a conversion, so there is no display tearing.
- Every digit of bcd_out is always in 0..9. The arithmetic cannot overflow for legal WIDTH/DIGITS.

## Timing
- Reset values (asynchronous, while reset_rtl_0 = 0):
  - bcd_out = 0, valid = 0, busy = 0, done = 0
  - last_bin = 0, pending = 1, state = IDLE
  - pending = 1 forces one conversion immediately after reset release.
- Latency: capture edge C, shifts on edges C+1..C+WIDTH, bcd_out/valid/done update at edge C+WIDTH+1 (17 edges for WIDTH = 16).
- busy is high from after edge C until after edge C+WIDTH+1.
- Next capture is possible at edge C+WIDTH+2, giving a throughput of one conversion per WIDTH+2 cycles.
- Reset mid-conversion: abort immediately and return to reset values. The partial result is discarded and a new conversion of the current bin_in starts on the first edge after release.
- Steady bin_in with no force: no activity; busy = 0, done = 0 indefinitely.

## Test plan
- Reset, bin_in = 0, release -> busy rises after first edge; at edge 18 done = 1 for one cycle, bcd_out = 0x00000, valid = 1.
- bin_in = 12345 held -> after conversion bcd_out = 0x12345. Then hold 200 cycles -> no further done pulses; bcd_out stable.
- bin_in = 65535 then 0 then 9 (each held until done) -> bcd_out sequence 0x65535, 0x00000, 0x00009.
- bin_in = 100, then 3 cycles after capture change to 27000 -> first done gives 0x00100 with bcd_out unchanged until then; second conversion auto-starts in IDLE giving 0x27000.
- force pulsed during SHIFT with bin_in constant at 999 -> exactly two done pulses total, both bcd_out = 0x00999.
- Assert reset_rtl_0 at shift 8 of converting 4242 -> outputs read 0/0/0/0 within the reset cycle (asynchronous); after release, 0x04242 appears 17 edges after the capture edge.
